// File: rtl/gyro_spi_reader.sv
// SPI mode-3 master for the L3G4200D gyro: one CTRL_REG1 write after reset,
// then periodic 7-byte burst reads of OUT_X_L..OUT_Z_H into dx/dy/dz.
module gyro_spi_reader #(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned SAMPLE_TICKS = 50000,
  parameter logic [7:0]  CTRL1_VAL    = 8'h0F
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        ss_o,
  output logic [15:0] dx_o,
  output logic [15:0] dy_o,
  output logic [15:0] dz_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        cfg_done_o
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TickW  = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
  localparam int unsigned FrameW = 56;
  localparam int unsigned RxW    = 48;
  localparam int unsigned BitW   = 6;

  localparam logic [7:0]        CfgReg    = 8'h20;
  localparam logic [7:0]        ReadCmd   = 8'hE8;
  localparam logic [FrameW-1:0] CfgFrame  = {CfgReg, CTRL1_VAL, 40'h0};
  localparam logic [FrameW-1:0] ReadFrame = {ReadCmd, 48'h0};

  typedef enum logic [1:0] {S_CFG, S_IDLE, S_READ, S_LATCH} state_e;
  typedef enum logic [2:0] {PH_OFF, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD, PH_GUARD} phase_e;

  state_e              state_q;
  phase_e              phase_q;
  logic [DivW-1:0]     cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [FrameW-2:0]   tx_q;
  logic [RxW-1:0]      rx_q;
  logic [TickW-1:0]    timer_q, timer_d;
  logic                pending_q, pending_d;
  logic                ss_q, sclk_q, mosi_q, busy_q, cfg_done_q, valid_q;
  logic [15:0]         dx_q, dy_q, dz_q;

  logic                run_c, wrap_c, start_read_c, start_cfg_c, start_frame_c;
  logic                cnt_last_c, frame_done_c;
  logic [FrameW-1:0]   frame_c;
  logic [BitW-1:0]     last_bit_c;

  // Control decode shared by the timer and the transaction engine
  always_comb begin
    run_c         = cfg_done_q & en_i;
    wrap_c        = run_c && (timer_q == TickW'(SAMPLE_TICKS - 1));
    start_read_c  = (state_q == S_IDLE) && pending_q && en_i;
    start_cfg_c   = (state_q == S_CFG) && (phase_q == PH_OFF);
    start_frame_c = start_cfg_c | start_read_c;
    frame_c       = start_cfg_c ? CfgFrame : ReadFrame;
    cnt_last_c    = (cnt_q == DivW'(CLK_DIV - 1));
    last_bit_c    = (state_q == S_CFG) ? BitW'(15) : BitW'(FrameW - 1);
    frame_done_c  = (phase_q == PH_GUARD) && cnt_last_c;
  end

  // Sample timer and pending-read flag; a wrap while busy is remembered once
  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!run_c) begin
      timer_d = '0;
    end else if (wrap_c) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    if (start_read_c) pending_d = 1'b0;
    if (wrap_c)       pending_d = 1'b1;
    if (!en_i)        pending_d = 1'b0;
  end

  // Timer/pending registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // Top FSM plus SPI framing engine: setup, 8N bits, hold, inter-frame guard
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_CFG;
      phase_q    <= PH_OFF;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      valid_q    <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      dz_q       <= '0;
    end else begin
      valid_q <= 1'b0;

      if (start_frame_c) begin
        // First bit goes out together with the SS falling edge
        ss_q      <= 1'b0;
        busy_q    <= 1'b1;
        mosi_q    <= frame_c[FrameW-1];
        tx_q      <= frame_c[FrameW-2:0];
        phase_q   <= PH_SETUP;
        cnt_q     <= '0;
        bit_cnt_q <= '0;
      end else if (phase_q != PH_OFF) begin
        cnt_q <= cnt_last_c ? '0 : cnt_q + 1'b1;
        if (cnt_last_c) begin
          case (phase_q)
            PH_SETUP: begin
              sclk_q  <= 1'b0;
              phase_q <= PH_LOW;
            end
            PH_LOW: begin
              sclk_q  <= 1'b1;
              rx_q    <= {rx_q[RxW-2:0], miso_i};
              phase_q <= PH_HIGH;
            end
            PH_HIGH: begin
              if (bit_cnt_q == last_bit_c) begin
                phase_q <= PH_HOLD;
              end else begin
                sclk_q    <= 1'b0;
                mosi_q    <= tx_q[FrameW-2];
                tx_q      <= {tx_q[FrameW-3:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                phase_q   <= PH_LOW;
              end
            end
            PH_HOLD: begin
              ss_q    <= 1'b1;
              phase_q <= PH_GUARD;
            end
            PH_GUARD: begin
              busy_q  <= 1'b0;
              phase_q <= PH_OFF;
            end
            default: phase_q <= PH_OFF;
          endcase
        end
      end

      case (state_q)
        S_CFG: begin
          if (frame_done_c) begin
            cfg_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (start_read_c) state_q <= S_READ;
        end
        S_READ: begin
          if (frame_done_c) state_q <= S_LATCH;
        end
        S_LATCH: begin
          // rx_q holds XL,XH,YL,YH,ZL,ZH from MSB down
          dx_q    <= {rx_q[39:32], rx_q[47:40]};
          dy_q    <= {rx_q[23:16], rx_q[31:24]};
          dz_q    <= {rx_q[7:0],   rx_q[15:8]};
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign ss_o       = ss_q;
  assign dx_o       = dx_q;
  assign dy_o       = dy_q;
  assign dz_o       = dz_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign cfg_done_o = cfg_done_q;

endmodule
